// File: rtl/vec_issue_pkg.sv
// Shared widths, depths and payload types for the vector issue path
// (decoder -> enqueue buffer -> sequencer).
package vec_issue_pkg;

   localparam int CMD_W_DEF        = 20;
   localparam int IMM_W_DEF        = 64;
   localparam int CMDQ_DEPTH_DEF   = 4;
   localparam int XIMM1Q_DEPTH_DEF = 4;

   typedef logic [CMD_W_DEF-1:0] cmd_t;
   typedef logic [IMM_W_DEF-1:0] imm_t;

endpackage

// File: rtl/vec_sync_fifo.sv
// Single-clock FIFO with occupancy count and modulo-DEPTH pointers. Any DEPTH >= 2
// is supported. Ready depends only on registered state, so there is no pass-through.
module vec_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [W-1:0]               wr_data,
   output logic                       wr_ready,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [W-1:0]               rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH-1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             wr_fire;
   logic             rd_fire;

   // DEPTH need not be a power of two, so wrap explicitly rather than overflow.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign wr_ready = (count_q != FULL_CNT);
   assign rd_valid = (count_q != '0);
   assign wr_fire  = wr_en & wr_ready;
   assign rd_fire  = rd_ready & rd_valid;
   assign rd_data  = mem[rd_ptr];
   assign count    = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_fire) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
         count_q <= count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
      end
   end

   // Payload storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/vec_cmd_ximm1_enq_buffer.sv
// Command and ximm1 issue queues behind the block decoder: atomic enqueue of an
// instruction's command/immediate, replay when a needed queue is full.
module vec_cmd_ximm1_enq_buffer
   import vec_issue_pkg::*;
#(
   parameter int CMDQ_DEPTH   = CMDQ_DEPTH_DEF,
   parameter int XIMM1Q_DEPTH = XIMM1Q_DEPTH_DEF,
   parameter int CMD_W        = CMD_W_DEF,
   parameter int IMM_W        = IMM_W_DEF
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              io_valid,
   input  logic                              io_sigs_enq_cmdq,
   input  logic                              io_sigs_enq_ximm1q,
   input  logic [CMD_W-1:0]                  io_enq_cmd,
   input  logic [IMM_W-1:0]                  io_enq_imm,
   output logic                              io_cmdq_ready,
   output logic                              io_ximm1q_ready,
   output logic                              io_replay,
   output logic                              io_deq_cmd_valid,
   input  logic                              io_deq_cmd_ready,
   output logic [CMD_W-1:0]                  io_deq_cmd_bits,
   output logic                              io_deq_imm_valid,
   input  logic                              io_deq_imm_ready,
   output logic [IMM_W-1:0]                  io_deq_imm_bits,
   output logic [$clog2(CMDQ_DEPTH+1)-1:0]   io_cmdq_count,
   output logic [$clog2(XIMM1Q_DEPTH+1)-1:0] io_ximm1q_count
);

   logic [1:0] rst_sync;
   logic       rst_n;
   logic       fire;
   logic       cmdq_wr;
   logic       ximm1q_wr;

   // Assert asynchronously, release two edges later in the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // Either queue lacking room blocks both writes, so a commit is never partial.
   assign io_replay = io_valid & ((io_sigs_enq_cmdq   & ~io_cmdq_ready) |
                                  (io_sigs_enq_ximm1q & ~io_ximm1q_ready));
   assign fire      = io_valid & ~io_replay;
   assign cmdq_wr   = fire & io_sigs_enq_cmdq;
   assign ximm1q_wr = fire & io_sigs_enq_ximm1q;

   vec_sync_fifo #(.DEPTH(CMDQ_DEPTH), .W(CMD_W)) u_cmdq (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (cmdq_wr),
      .wr_data  (io_enq_cmd),
      .wr_ready (io_cmdq_ready),
      .rd_valid (io_deq_cmd_valid),
      .rd_ready (io_deq_cmd_ready),
      .rd_data  (io_deq_cmd_bits),
      .count    (io_cmdq_count)
   );

   vec_sync_fifo #(.DEPTH(XIMM1Q_DEPTH), .W(IMM_W)) u_ximm1q (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (ximm1q_wr),
      .wr_data  (io_enq_imm),
      .wr_ready (io_ximm1q_ready),
      .rd_valid (io_deq_imm_valid),
      .rd_ready (io_deq_imm_ready),
      .rd_data  (io_deq_imm_bits),
      .count    (io_ximm1q_count)
   );

endmodule

// File: tb/tb_vec_cmd_ximm1_enq_buffer.sv
// Bench for vec_cmd_ximm1_enq_buffer: vector table, scoreboard queues, reset,
// non-power-of-two wrap and random traffic.
module tb_vec_cmd_ximm1_enq_buffer;
   import vec_issue_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // Main DUT, default depths of 4
   logic       io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q;
   cmd_t       io_enq_cmd;
   imm_t       io_enq_imm;
   logic       io_cmdq_ready, io_ximm1q_ready, io_replay;
   logic       io_deq_cmd_valid, io_deq_cmd_ready, io_deq_imm_valid, io_deq_imm_ready;
   cmd_t       io_deq_cmd_bits;
   imm_t       io_deq_imm_bits;
   logic [2:0] io_cmdq_count, io_ximm1q_count;

   // Depth-3 DUT for the wrap test
   logic       v3, sc3, sx3, dc3, di3;
   cmd_t       cmd3, dcmd3;
   imm_t       imm3, dimm3;
   logic       crdy3, xrdy3, rep3, dcv3, div3;
   logic [1:0] cc3, xc3;

   int checks = 0;
   int errors = 0;
   int mc = 0;
   int mx = 0;
   cmd_t cmd_q[$];
   imm_t imm_q[$];

   vec_cmd_ximm1_enq_buffer dut (
      .clk(clk), .reset_n(reset_n), .io_valid(io_valid),
      .io_sigs_enq_cmdq(io_sigs_enq_cmdq), .io_sigs_enq_ximm1q(io_sigs_enq_ximm1q),
      .io_enq_cmd(io_enq_cmd), .io_enq_imm(io_enq_imm),
      .io_cmdq_ready(io_cmdq_ready), .io_ximm1q_ready(io_ximm1q_ready), .io_replay(io_replay),
      .io_deq_cmd_valid(io_deq_cmd_valid), .io_deq_cmd_ready(io_deq_cmd_ready),
      .io_deq_cmd_bits(io_deq_cmd_bits), .io_deq_imm_valid(io_deq_imm_valid),
      .io_deq_imm_ready(io_deq_imm_ready), .io_deq_imm_bits(io_deq_imm_bits),
      .io_cmdq_count(io_cmdq_count), .io_ximm1q_count(io_ximm1q_count)
   );

   vec_cmd_ximm1_enq_buffer #(.CMDQ_DEPTH(3), .XIMM1Q_DEPTH(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .io_valid(v3),
      .io_sigs_enq_cmdq(sc3), .io_sigs_enq_ximm1q(sx3),
      .io_enq_cmd(cmd3), .io_enq_imm(imm3),
      .io_cmdq_ready(crdy3), .io_ximm1q_ready(xrdy3), .io_replay(rep3),
      .io_deq_cmd_valid(dcv3), .io_deq_cmd_ready(dc3), .io_deq_cmd_bits(dcmd3),
      .io_deq_imm_valid(div3), .io_deq_imm_ready(di3), .io_deq_imm_bits(dimm3),
      .io_cmdq_count(cc3), .io_ximm1q_count(xc3)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Occupancy bounds, checked every cycle
   always @(negedge clk) begin
      if (reset_n) begin
         checkOutput("cmdq_count_bound", 64'(io_cmdq_count <= 3'd4), 64'd1);
         checkOutput("ximm1q_count_bound", 64'(io_ximm1q_count <= 3'd4), 64'd1);
         checkOutput("d3_count_bound", 64'((cc3 <= 2'd3) && (xc3 <= 2'd3)), 64'd1);
      end
   end

   task automatic idleInputs();
      io_valid = 0; io_sigs_enq_cmdq = 0; io_sigs_enq_ximm1q = 0;
      io_deq_cmd_ready = 0; io_deq_imm_ready = 0;
      io_enq_cmd = '0; io_enq_imm = '0;
   endtask

   // Called at posedge+1; returns at the next posedge+1 with the sampled replay.
   task automatic applyStimulus(input logic v, sc, sx, dc, di, input cmd_t cmd,
                                input imm_t imm, output logic rep_seen);
      logic exp_rep;
      io_valid = v; io_sigs_enq_cmdq = sc; io_sigs_enq_ximm1q = sx;
      io_deq_cmd_ready = dc; io_deq_imm_ready = di;
      io_enq_cmd = cmd; io_enq_imm = imm;
      #4;
      exp_rep = v & ((sc & (mc == 4)) | (sx & (mx == 4)));
      rep_seen = io_replay;
      checkOutput("replay", 64'(io_replay), 64'(exp_rep));
      checkOutput("cmdq_ready", 64'(io_cmdq_ready), 64'(mc != 4));
      checkOutput("ximm1q_ready", 64'(io_ximm1q_ready), 64'(mx != 4));
      checkOutput("cmd_valid", 64'(io_deq_cmd_valid), 64'(mc != 0));
      checkOutput("imm_valid", 64'(io_deq_imm_valid), 64'(mx != 0));
      if (dc && cmd_q.size() > 0) begin
         checkOutput("cmd_order", 64'(io_deq_cmd_bits), 64'(cmd_q.pop_front()));
         mc--;
      end
      if (di && imm_q.size() > 0) begin
         checkOutput("imm_order", io_deq_imm_bits, imm_q.pop_front());
         mx--;
      end
      if (v && !exp_rep) begin
         if (sc) begin cmd_q.push_back(cmd); mc++; end
         if (sx) begin imm_q.push_back(imm); mx++; end
      end
      @(posedge clk); #1;
      checkOutput("cmdq_count", 64'(io_cmdq_count), 64'(mc));
      checkOutput("ximm1q_count", 64'(io_ximm1q_count), 64'(mx));
   endtask

   typedef struct {
      logic v, sc, sx, dc, di, r;
      int   cc, xc;
   } vec_t;
   vec_t tbl[16];

   initial begin
      logic rep;
      // {valid, enq_cmdq, enq_ximm1q, deq_cmd_ready, deq_imm_ready, replay, cmd count, imm count}
      tbl[0]  = '{1,1,0,0,0,0,1,0};
      tbl[1]  = '{1,1,0,0,0,0,2,0};
      tbl[2]  = '{1,1,0,0,0,0,3,0};
      tbl[3]  = '{1,1,0,0,0,0,4,0};
      tbl[4]  = '{1,1,0,0,0,1,4,0};
      tbl[5]  = '{1,1,1,0,0,1,4,0};
      tbl[6]  = '{1,1,0,1,0,1,3,0};
      tbl[7]  = '{1,1,0,0,0,0,4,0};
      tbl[8]  = '{1,0,0,0,0,0,4,0};
      tbl[9]  = '{0,1,1,0,0,0,4,0};
      tbl[10] = '{1,0,1,0,0,0,4,1};
      tbl[11] = '{1,0,1,1,1,0,3,1};
      tbl[12] = '{0,0,0,1,1,0,2,0};
      tbl[13] = '{0,0,0,1,1,0,1,0};
      tbl[14] = '{0,0,0,1,0,0,0,0};
      tbl[15] = '{0,0,0,1,1,0,0,0};

      idleInputs();
      v3 = 0; sc3 = 0; sx3 = 0; dc3 = 0; di3 = 0; cmd3 = '0; imm3 = '0;
      reset_n = 0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cmdq_count", 64'(io_cmdq_count), 64'd0);
      checkOutput("rst_cmd_valid", 64'(io_deq_cmd_valid), 64'd0);
      checkOutput("rst_ready", 64'({io_cmdq_ready, io_ximm1q_ready}), 64'd3);
      checkOutput("rst_replay", 64'(io_replay), 64'd0);

      // Reset mid-stream takes effect before the next clock edge
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, cmd_t'(20'h50 + i), imm_t'(64'h77 + i), rep);
      idleInputs();
      reset_n = 0;
      #1;
      checkOutput("amid_cmdq_count", 64'(io_cmdq_count), 64'd0);
      checkOutput("amid_ximm1q_count", 64'(io_ximm1q_count), 64'd0);
      checkOutput("amid_valids", 64'({io_deq_cmd_valid, io_deq_imm_valid}), 64'd0);
      checkOutput("amid_readies", 64'({io_cmdq_ready, io_ximm1q_ready}), 64'd3);
      cmd_q.delete(); imm_q.delete(); mc = 0; mx = 0;
      @(posedge clk); #1 reset_n = 1;
      repeat (3) @(posedge clk);
      #1;

      // Fill, full-queue replay, atomicity, full+deq, drain, empty-dequeue
      for (int i = 0; i < 16; i++) begin
         applyStimulus(tbl[i].v, tbl[i].sc, tbl[i].sx, tbl[i].dc, tbl[i].di,
                       cmd_t'(20'hA0 + i), imm_t'(64'h1000 + i), rep);
         checkOutput($sformatf("tbl%0d_replay", i), 64'(rep), 64'(tbl[i].r));
         checkOutput($sformatf("tbl%0d_cmdq_count", i), 64'(io_cmdq_count), 64'(tbl[i].cc));
         checkOutput($sformatf("tbl%0d_ximm1q_count", i), 64'(io_ximm1q_count), 64'(tbl[i].xc));
      end

      // Depth 3: seven back-to-back enq/deq pairs wrap pointers twice
      for (int i = 0; i < 7; i++) begin
         v3 = 1; sc3 = 1; sx3 = 1; dc3 = 1; di3 = 1;
         cmd3 = cmd_t'(i); imm3 = imm_t'(i);
         #4;
         checkOutput("d3_replay", 64'(rep3), 64'd0);
         checkOutput("d3_valid", 64'({dcv3, div3}), (i == 0) ? 64'd0 : 64'd3);
         if (i > 0) begin
            checkOutput("d3_cmd_order", 64'(dcmd3), 64'(i - 1));
            checkOutput("d3_imm_order", dimm3, 64'(i - 1));
         end
         @(posedge clk); #1;
         checkOutput("d3_count", 64'({cc3, xc3}), 64'b0101);
      end
      v3 = 0; sc3 = 0; sx3 = 0;
      #4;
      checkOutput("d3_cmd_last", 64'(dcmd3), 64'd6);
      checkOutput("d3_imm_last", dimm3, 64'd6);
      @(posedge clk); #1;
      checkOutput("d3_drained", 64'({cc3, xc3}), 64'd0);
      dc3 = 0; di3 = 0;

      // Random traffic against the scoreboard
      for (int i = 0; i < 10000; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                       ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                       cmd_t'($urandom), {$urandom, $urandom}, rep);
      end

      idleInputs();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
